// File: rtl/alarm_sequencer.sv
// -----------------------------------------------------------------------------
// alarm_sequencer
//   Intruder-alarm sequencer with an exit delay after arming, an entry delay
//   for the door zone, an instant window zone and a timed alarm that re-arms
//   itself when the sounding period runs out.
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   asynchronous active-high reset
//   arm      in   arm request (level)
//   disarm   in   disarm request (level, highest priority)
//   a        in   delayed-zone sensor (door), 1 = tripped
//   b        in   instant-zone sensor (window), 1 = tripped
//   q        out  alarm drive, 1 only in ALARM
//   q_bar    out  inverse of q
//   armed    out  1 in EXIT, ARMED, ENTRY or ALARM
//   tripped  out  sticky: ALARM entered since the last accepted arm
//   state    out  current state code
// -----------------------------------------------------------------------------
module alarm_sequencer #(
  parameter int EXIT_CYC  = 8,
  parameter int ENTRY_CYC = 4,
  parameter int ALARM_CYC = 16,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm,
  input  logic       disarm,
  input  logic       a,
  input  logic       b,
  output logic       q,
  output logic       q_bar,
  output logic       armed,
  output logic       tripped,
  output logic [2:0] state
);

  localparam logic [2:0] S_DISARMED = 3'd0;
  localparam logic [2:0] S_EXIT     = 3'd1;
  localparam logic [2:0] S_ARMED    = 3'd2;
  localparam logic [2:0] S_ENTRY    = 3'd3;
  localparam logic [2:0] S_ALARM    = 3'd4;

  // Delays are loaded as N-1 so that the state is held for exactly N cycles.
  localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_CYC - 1);
  localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_CYC - 1);
  localparam logic [CNT_W-1:0] ALARM_LD = CNT_W'(ALARM_CYC - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tripped_q, tripped_d;
  logic             cnt_zero_s;
  logic [CNT_W-1:0] cnt_dec_s;

  assign cnt_zero_s = (cnt_q == {CNT_W{1'b0}});
  // Only used while the counter is nonzero, so it never wraps.
  assign cnt_dec_s  = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};

  // State, delay counter and sticky trip flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_DISARMED;
      cnt_q     <= {CNT_W{1'b0}};
      tripped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tripped_q <= tripped_d;
    end
  end

  // Next-state logic; priority in every state is disarm > b > a > arm.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tripped_d = tripped_q;
    case (state_q)
      S_DISARMED: begin
        if (arm && !disarm) begin
          state_d   = S_EXIT;
          cnt_d     = EXIT_LD;
          tripped_d = 1'b0;
        end else begin
          state_d = S_DISARMED;
        end
      end
      S_EXIT: begin
        if (disarm) begin
          state_d = S_DISARMED;
        end else if (cnt_zero_s) begin
          state_d = S_ARMED;
        end else begin
          cnt_d = cnt_dec_s;
        end
      end
      S_ARMED: begin
        if (disarm) begin
          state_d = S_DISARMED;
        end else if (b) begin
          state_d   = S_ALARM;
          cnt_d     = ALARM_LD;
          tripped_d = 1'b1;
        end else if (a) begin
          state_d = S_ENTRY;
          cnt_d   = ENTRY_LD;
        end else begin
          state_d = S_ARMED;
        end
      end
      S_ENTRY: begin
        if (disarm) begin
          state_d = S_DISARMED;
        end else if (b || cnt_zero_s) begin
          state_d   = S_ALARM;
          cnt_d     = ALARM_LD;
          tripped_d = 1'b1;
        end else begin
          cnt_d = cnt_dec_s;
        end
      end
      S_ALARM: begin
        if (disarm) begin
          state_d = S_DISARMED;
        end else if (cnt_zero_s) begin
          // Auto re-arm straight to ARMED; tripped stays set.
          state_d = S_ARMED;
        end else begin
          cnt_d = cnt_dec_s;
        end
      end
      default: begin
        // Unused codes recover to a safe state.
        state_d = S_DISARMED;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    state   = state_q;
    tripped = tripped_q;
    q       = (state_q == S_ALARM);
    q_bar   = (state_q != S_ALARM);
    armed   = (state_q == S_EXIT) || (state_q == S_ARMED) ||
              (state_q == S_ENTRY) || (state_q == S_ALARM);
  end

endmodule

// File: tb/tb_alarm_sequencer.sv
module tb_alarm_sequencer;

  logic       clk;
  logic       rst;
  logic       arm;
  logic       disarm;
  logic       a;
  logic       b;
  logic       q;
  logic       q_bar;
  logic       armed;
  logic       tripped;
  logic [2:0] state;

  int vectors;
  int miscompares;

  alarm_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .arm     (arm),
    .disarm  (disarm),
    .a       (a),
    .b       (b),
    .q       (q),
    .q_bar   (q_bar),
    .armed   (armed),
    .tripped (tripped),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic qv,
                         input logic arv, input logic trv);
    chk({tag, ".state"},   {5'd0, state}, {5'd0, st});
    chk({tag, ".q"},       {7'd0, q},       {7'd0, qv});
    chk({tag, ".q_bar"},   {7'd0, q_bar},   {7'd0, ~qv});
    chk({tag, ".armed"},   {7'd0, armed},   {7'd0, arv});
    chk({tag, ".tripped"}, {7'd0, tripped}, {7'd0, trv});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1; arm = 1'b0; disarm = 1'b0; a = 1'b0; b = 1'b0;
    #1;
    chk_all("reset", 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk_all("idle", 3'd0, 1'b0, 1'b0, 1'b0);

    // a/b ignored while disarmed
    a = 1'b1; b = 1'b1;
    step();
    a = 1'b0; b = 1'b0;
    chk_all("dis_ab", 3'd0, 1'b0, 1'b0, 1'b0);

    // Arm: EXIT for 8 cycles then ARMED
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_all("exit", 3'd1, 1'b0, 1'b1, 1'b0);
      step();
    end
    chk_all("armed", 3'd2, 1'b0, 1'b1, 1'b0);

    // Entry delay 4 cycles, alarm 16 cycles, auto re-arm
    a = 1'b1;
    step();
    a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_all("entry", 3'd3, 1'b0, 1'b1, 1'b0);
      step();
    end
    for (int i = 0; i < 16; i++) begin
      chk_all("alarm", 3'd4, 1'b1, 1'b1, 1'b1);
      step();
    end
    chk_all("rearm", 3'd2, 1'b0, 1'b1, 1'b1);

    // a and b together in ARMED: b wins, straight to ALARM
    a = 1'b1; b = 1'b1;
    step();
    a = 1'b0; b = 1'b0;
    chk_all("ab_alarm", 3'd4, 1'b1, 1'b1, 1'b1);

    // disarm beats b in ALARM; tripped retained
    disarm = 1'b1; b = 1'b1;
    step();
    disarm = 1'b0; b = 1'b0;
    chk_all("alarm_disarm", 3'd0, 1'b0, 1'b0, 1'b1);

    // arm together with disarm is not accepted
    arm = 1'b1; disarm = 1'b1;
    step();
    disarm = 1'b0;
    chk_all("arm_disarm", 3'd0, 1'b0, 1'b0, 1'b1);

    // accepted arm clears tripped; disarm during EXIT
    step();
    arm = 1'b0;
    chk_all("rearm_clr", 3'd1, 1'b0, 1'b1, 1'b0);
    step();
    disarm = 1'b1;
    step();
    disarm = 1'b0;
    chk_all("exit_disarm", 3'd0, 1'b0, 1'b0, 1'b0);

    // Arm again, reach ENTRY, b jumps to ALARM
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk_all("armed2", 3'd2, 1'b0, 1'b1, 1'b0);
    a = 1'b1;
    step();
    a = 1'b0;
    step();
    chk_all("entry2", 3'd3, 1'b0, 1'b1, 1'b0);
    b = 1'b1;
    step();
    b = 1'b0;
    chk_all("entry_b", 3'd4, 1'b1, 1'b1, 1'b1);

    // Back to ARMED via disarm+arm, then disarm during ENTRY
    disarm = 1'b1;
    step();
    disarm = 1'b0;
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int i = 0; i < 8; i++) step();
    a = 1'b1;
    step();
    a = 1'b0;
    step();
    chk_all("entry3", 3'd3, 1'b0, 1'b1, 1'b0);
    disarm = 1'b1;
    step();
    disarm = 1'b0;
    chk_all("entry_disarm", 3'd0, 1'b0, 1'b0, 1'b0);

    // Async reset mid-ALARM
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int i = 0; i < 8; i++) step();
    b = 1'b1;
    step();
    b = 1'b0;
    step();
    step();
    chk_all("pre_rst", 3'd4, 1'b1, 1'b1, 1'b1);
    #2;
    rst = 1'b1; a = 1'b1; b = 1'b1; arm = 1'b1;
    #1;
    chk_all("async_rst", 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk_all("rst_hold", 3'd0, 1'b0, 1'b0, 1'b0);
    a = 1'b0; b = 1'b0; arm = 1'b0;
    rst = 1'b0;
    step();
    chk_all("post_rst", 3'd0, 1'b0, 1'b0, 1'b0);

    // No residual count: fresh arm gives a full 8-cycle EXIT
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk({"exit_fresh", ".state"}, {5'd0, state}, 8'd1);
      step();
    end
    chk({"exit_fresh_end", ".state"}, {5'd0, state}, 8'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 The block SHALL have parameter EXIT_CYC, default 8, exit-delay length in clk cycles (legal 1..2^CNT_W).
REQ-002 The block SHALL have parameter ENTRY_CYC, default 4, entry-delay length in clk cycles (legal 1..2^CNT_W).
REQ-003 The block SHALL have parameter ALARM_CYC, default 16, alarm-sounding length in clk cycles (legal 1..2^CNT_W).
REQ-004 The block SHALL have parameter CNT_W, default 8, delay counter width.
REQ-005 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 The block SHALL have port arm  input  1  arm request, level, sampled each cycle.
REQ-008 The block SHALL have port disarm  input  1  disarm request, level, sampled each cycle.
REQ-009 The block SHALL have port a  input  1  delayed-zone sensor (door); 1 = tripped.
REQ-010 The block SHALL have port b  input  1  instant-zone sensor (window); 1 = tripped.
REQ-011 The block SHALL have port q  output  1  alarm drive; 1 only in ALARM state.
REQ-012 The block SHALL have port q_bar  output  1  always the inverse of q.
REQ-013 The block SHALL have port armed  output  1  1 in EXIT, ARMED, ENTRY or ALARM.
REQ-014 The block SHALL have port tripped  output  1  sticky flag: ALARM entered since last accepted arm.
REQ-015 The block SHALL have port state  output  3  current state code.

Function
REQ-016 The block SHALL implement states DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4; codes 5-7 SHALL go to DISARMED next cycle.
REQ-017 All outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs.
REQ-018 Input priority in every state SHALL be disarm > b > a > arm.
REQ-019 DISARMED: arm=1 and disarm=0 -> EXIT, counter loaded EXIT_CYC-1, tripped cleared; a, b ignored.
REQ-020 EXIT: disarm -> DISARMED; else counter==0 -> ARMED; else decrement; a, b, arm ignored; EXIT lasts exactly EXIT_CYC cycles.
REQ-021 ARMED: disarm -> DISARMED; else b=1 -> ALARM; else a=1 -> ENTRY with counter loaded ENTRY_CYC-1; arm ignored.
REQ-022 ENTRY: disarm -> DISARMED; else b=1 -> ALARM; else counter==0 -> ALARM; else decrement; a ignored; ENTRY lasts exactly ENTRY_CYC cycles absent b/disarm.
REQ-023 Every entry to ALARM SHALL load the counter with ALARM_CYC-1 and set tripped.
REQ-024 ALARM: disarm -> DISARMED; else counter==0 -> ARMED (auto re-arm, no exit delay); else decrement; a, b ignored while sounding.
REQ-025 Simultaneous a=1 and b=1 in ARMED SHALL go to ALARM (b wins).
REQ-026 Counter SHALL never wrap: loaded only on state entry, decremented only while nonzero.
REQ-027 tripped SHALL be unaffected by disarm and by auto re-arm; cleared only by rst or accepted arm.
REQ-028 q SHALL be 1 on the first cycle the state register holds ALARM and 0 on the first cycle it leaves.

Reset
REQ-029 rst=1 SHALL immediately, without clk, force state=DISARMED, counter=0, q=0, q_bar=1, armed=0, tripped=0.
REQ-030 While rst=1 all inputs SHALL be ignored; first transition possible on first rising clk edge after rst falls.
REQ-031 Reset asserted mid-delay or mid-alarm SHALL abort it with no residual count.

Verification
REQ-032 Arm sequence: rst pulse, arm=1 one cycle -> state=1 for 8 cycles, then state=2; armed=1 throughout; q=0.
REQ-033 Entry delay: in ARMED, a=1 one cycle -> state=3 for 4 cycles, then state=4, q=1, q_bar=0, tripped=1 for 16 cycles, then state=2, q=0, tripped stays 1.
REQ-034 Instant zone and priority: in ARMED, a=1 and b=1 same cycle -> state=4 next cycle; in ENTRY, b=1 -> state=4 next cycle; in ALARM, disarm=1 and b=1 -> state=0.
REQ-035 Disarm paths: disarm=1 in EXIT, ENTRY and ALARM each -> state=0 next cycle, q=0, armed=0; tripped retains prior value; subsequent arm clears tripped.
REQ-036 Async reset: assert rst between clk edges mid-ALARM -> q=0, q_bar=1, state=0, tripped=0 before next edge; a=1/b=1/arm=1 during rst -> no state change.
